// File: rtl/multibyte_add_seq_if.sv
// rtl/multibyte_add_seq_if.sv - operand, result and adder-side signals of the multibyte add sequencer
// slave is the sequencer; master is its surroundings (requester, consumer and 8-bit adder).
interface multibyte_add_seq_if #(
   parameter int N_BYTES = 4
);
   localparam int W = 8 * N_BYTES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_cin;

   logic [7:0]   add_a;
   logic [7:0]   add_b;
   logic         add_c_in;
   logic [7:0]   add_sum;
   logic         add_c_out;

   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_c_out;

   modport slave (
      input  in_valid, in_a, in_b, in_cin, add_sum, add_c_out, out_ready,
      output in_ready, add_a, add_b, add_c_in, out_valid, out_sum, out_c_out
   );

   modport master (
      output in_valid, in_a, in_b, in_cin, add_sum, add_c_out, out_ready,
      input  in_ready, add_a, add_b, add_c_in, out_valid, out_sum, out_c_out
   );
endinterface

// File: rtl/multibyte_add_seq.sv
// rtl/multibyte_add_seq.sv - byte-serial W-bit adder sequencer around an external 8-bit adder
// Accepts operands, walks one byte per clock through the adder, then holds the result until taken.
module multibyte_add_seq #(
   parameter int N_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   multibyte_add_seq_if.slave     bus
);
   localparam int W  = 8 * N_BYTES;
   localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic          cin_q, cin_d;
   logic          carry_q, carry_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          cout_q, cout_d;

   logic [7:0]    add_a;
   logic [7:0]    add_b;
   logic          add_c_in;
   logic          in_ready;
   logic          out_valid;
   logic [IW+2:0] bit_ofs;

   assign bit_ofs = {idx_q, 3'b000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      a_d       = a_q;
      b_d       = b_q;
      cin_d     = cin_q;
      carry_d   = carry_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      add_a     = 8'h00;
      add_b     = 8'h00;
      add_c_in  = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               cin_d   = bus.in_cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            add_a    = a_q[bit_ofs +: 8];
            add_b    = b_q[bit_ofs +: 8];
            // byte 0 takes the requester's carry, later bytes chain the adder's previous c_out
            add_c_in = (idx_q == '0) ? cin_q : carry_q;
            sum_d[bit_ofs +: 8] = bus.add_sum;
            carry_d  = bus.add_c_out;
            if (idx_q == LAST_IDX) begin
               cout_d  = bus.add_c_out;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = in_ready;
   assign bus.add_a     = add_a;
   assign bus.add_b     = add_b;
   assign bus.add_c_in  = add_c_in;
   assign bus.out_valid = out_valid;
   assign bus.out_sum   = sum_q;
   assign bus.out_c_out = cout_q;
endmodule

// File: tb/tb_multibyte_add_seq.sv
// tb/tb_multibyte_add_seq.sv - scoreboard bench for multibyte_add_seq (N_BYTES=4 and N_BYTES=1)
module tb_multibyte_add_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multibyte_add_seq_if #(.N_BYTES(4)) bus0 ();
   multibyte_add_seq_if #(.N_BYTES(1)) bus1 ();

   multibyte_add_seq #(.N_BYTES(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   multibyte_add_seq #(.N_BYTES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   // behavioural stand-in for the team's 8-bit combinational adder
   assign {bus0.add_c_out, bus0.add_sum} = {1'b0, bus0.add_a} + {1'b0, bus0.add_b} + {8'h00, bus0.add_c_in};
   assign {bus1.add_c_out, bus1.add_sum} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {8'h00, bus1.add_c_in};

   typedef struct {
      logic [31:0] sum;
      logic        cout;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [31:0] s, input logic c);
      exp_t e;
      e.sum = s; e.cout = c;
      q0.push_back(e);
   endtask

   task automatic push1(input logic [7:0] s, input logic c);
      exp_t e;
      e.sum = {24'h0, s}; e.cout = c;
      q1.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus0.out_valid && bus0.out_ready) begin
         if (q0.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL mon0_unexpected: got result 0x%0h, expected none", bus0.out_sum);
         end else begin
            exp_t e;
            e = q0.pop_front();
            check("mon0_sum", {32'h0, bus0.out_sum}, {32'h0, e.sum});
            check("mon0_cout", {63'h0, bus0.out_c_out}, {63'h0, e.cout});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus1.out_valid && bus1.out_ready) begin
         if (q1.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL mon1_unexpected: got result 0x%0h, expected none", bus1.out_sum);
         end else begin
            exp_t e;
            e = q1.pop_front();
            check("mon1_sum", {56'h0, bus1.out_sum}, {32'h0, e.sum});
            check("mon1_cout", {63'h0, bus1.out_c_out}, {63'h0, e.cout});
         end
      end
   end

   logic [7:0] a1 [3] = '{8'd1, 8'd10, 8'd55};
   logic [7:0] b1 [3] = '{8'd2, 8'd20, 8'd66};
   logic       c1 [3] = '{1'b1, 1'b0, 1'b1};
   logic [7:0] s1 [3] = '{8'h04, 8'h1E, 8'h7A};

   initial begin
      bus0.in_valid = 0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_cin = 0; bus0.out_ready = 1;
      bus1.in_valid = 0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 0; bus1.out_ready = 1;

      // reset state
      #3;
      check("rst_out_valid", {63'h0, bus0.out_valid}, 64'h0);
      check("rst_out_sum", {32'h0, bus0.out_sum}, 64'h0);
      check("rst_add_a", {56'h0, bus0.add_a}, 64'h0);
      repeat (2) tick();
      #2 rst_n = 1;
      tick();
      check("rst_in_ready", {63'h0, bus0.in_ready}, 64'h1);

      // 1: 0xFF + 0x01, carry into byte 1, latency of 4 edges
      bus0.in_a = 32'h0000_00FF; bus0.in_b = 32'h0000_0001; bus0.in_cin = 0; bus0.in_valid = 1;
      push0(32'h0000_0100, 1'b0);
      tick();
      bus0.in_valid = 0;
      check("t1_in_ready_run", {63'h0, bus0.in_ready}, 64'h0);
      check("t1_cin_b0", {63'h0, bus0.add_c_in}, 64'h0);
      check("t1_add_a_b0", {56'h0, bus0.add_a}, 64'hFF);
      tick();
      check("t1_cin_b1", {63'h0, bus0.add_c_in}, 64'h1);
      tick(); tick();
      check("t1_valid_early", {63'h0, bus0.out_valid}, 64'h0);
      tick();
      check("t1_valid_at4", {63'h0, bus0.out_valid}, 64'h1);
      check("t1_add_a_done", {56'h0, bus0.add_a}, 64'h0);
      tick();
      check("t1_idle_in_ready", {63'h0, bus0.in_ready}, 64'h1);

      // 2: 0xFFFFFFFF + 0 + cin=1, carry ripples through every byte
      bus0.in_a = 32'hFFFF_FFFF; bus0.in_b = 32'h0; bus0.in_cin = 1; bus0.in_valid = 1;
      push0(32'h0000_0000, 1'b1);
      tick();
      bus0.in_valid = 0;
      for (int i = 0; i < 4; i++) begin
         check("t2_carry_chain", {63'h0, bus0.add_c_in}, 64'h1);
         tick();
      end
      check("t2_valid", {63'h0, bus0.out_valid}, 64'h1);
      tick();

      // 3: N_BYTES=1, back-to-back with in_valid held and operands changing mid-flight
      for (int k = 0; k < 3; k++) begin
         bus1.in_a = a1[k]; bus1.in_b = b1[k]; bus1.in_cin = c1[k]; bus1.in_valid = 1;
         check("t3_in_ready_idle", {63'h0, bus1.in_ready}, 64'h1);
         push1(s1[k], 1'b0);
         tick();
         bus1.in_a = 8'hEE; bus1.in_b = 8'hEE; bus1.in_cin = 1;
         check("t3_in_ready_run", {63'h0, bus1.in_ready}, 64'h0);
         tick();
         check("t3_valid_done", {63'h0, bus1.out_valid}, 64'h1);
         check("t3_in_ready_done", {63'h0, bus1.in_ready}, 64'h0);
         tick();
      end
      bus1.in_valid = 0;

      // 4: backpressure holds the result
      bus0.out_ready = 0;
      bus0.in_a = 32'h1234_5678; bus0.in_b = 32'h1111_1111; bus0.in_cin = 0; bus0.in_valid = 1;
      push0(32'h2345_6789, 1'b0);
      tick();
      bus0.in_valid = 0;
      repeat (4) tick();
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_valid", {63'h0, bus0.out_valid}, 64'h1);
         check("t4_hold_sum", {32'h0, bus0.out_sum}, 64'h2345_6789);
         check("t4_hold_in_ready", {63'h0, bus0.in_ready}, 64'h0);
         bus0.in_valid = (i % 2 == 0);
         bus0.in_a = 32'hDEAD_BEEF;
         tick();
      end
      bus0.in_valid = 0;
      bus0.out_ready = 1;
      tick();
      check("t4_release_idle", {63'h0, bus0.in_ready}, 64'h1);
      check("t4_release_valid", {63'h0, bus0.out_valid}, 64'h0);

      // 5: asynchronous reset at idx=2 aborts the operation
      bus0.in_a = 32'hA5A5_A5A5; bus0.in_b = 32'h0101_0101; bus0.in_cin = 0; bus0.in_valid = 1;
      tick();
      bus0.in_valid = 0;
      tick(); tick();
      check("t5_pre_add_a", {56'h0, bus0.add_a}, 64'hA5);
      #2 rst_n = 0;
      #1;
      check("t5_rst_add_a", {56'h0, bus0.add_a}, 64'h0);
      check("t5_rst_sum", {32'h0, bus0.out_sum}, 64'h0);
      check("t5_rst_valid", {63'h0, bus0.out_valid}, 64'h0);
      tick();
      check("t5_rst_hold_valid", {63'h0, bus0.out_valid}, 64'h0);
      #2 rst_n = 1;
      tick();
      bus0.in_a = 32'h1; bus0.in_b = 32'h1; bus0.in_cin = 0; bus0.in_valid = 1;
      push0(32'h0000_0002, 1'b0);
      tick();
      bus0.in_valid = 0;
      repeat (5) tick();

      // 6: in_valid held high; operands changing mid-RUN are ignored
      bus0.in_a = 32'h0102_0304; bus0.in_b = 32'h1020_3040; bus0.in_cin = 0; bus0.in_valid = 1;
      push0(32'h1122_3344, 1'b0);
      tick();
      bus0.in_a = 32'hFFFF_FFFF; bus0.in_b = 32'hFFFF_FFFF;
      repeat (5) tick();
      push0(32'hFFFF_FFFE, 1'b1);
      tick();
      bus0.in_valid = 0;
      bus0.in_a = 32'h0; bus0.in_b = 32'h0;
      repeat (5) tick();
      check("t6_back_idle", {63'h0, bus0.in_ready}, 64'h1);

      check("q0_drained", {32'h0, q0.size()}, 64'h0);
      check("q1_drained", {32'h0, q1.size()}, 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
